// File: rtl/rf_pkg.sv
// Shared sizing defaults, address-width helper and typedefs for the scoreboarded register file.
package rf_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_REG      = 0;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef logic [XLEN_DEFAULT-1:0]              reg_data_t;
    typedef logic [addr_width(NREGS_DEFAULT)-1:0] reg_addr_t;
endpackage

// File: rtl/rf_sb_bits.sv
// Pending-bit scoreboard: one flop per register, issue-set beats write-back-clear.
// RF_WRITE_BYPASS_EN makes the rsN_busy lookups see a same-cycle write-back clear.
module rf_sb_bits import rf_pkg::*; #(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr,
    input  logic [AW-1:0]    clr_addr,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             busy_any,
    output logic [NREGS-1:0] pending
);
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] visible;

    always_comb begin
        set_vec           = '0;
        clr_vec           = '0;
        set_vec[set_addr] = set;
        clr_vec[clr_addr] = clr;
        set_vec[ZERO_REG] = 1'b0;  // x0 can never be in flight
        pending_next      = set_vec | (pending & ~clr_vec);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= pending_next;
    end

`ifdef RF_WRITE_BYPASS_EN
    assign visible = pending & ~(clr_vec & ~set_vec);
`else
    assign visible = pending;
`endif

    assign rs1_busy = visible[rs1_addr];
    assign rs2_busy = visible[rs2_addr];
    assign busy_any = |pending;
endmodule

// File: rtl/rf_scoreboard_regfile.sv
// Integer register file with main write port, handshaked long-latency write-back and pending scoreboard.
// RF_WRITE_BYPASS_EN forwards same-cycle write data to the read ports and debug tap.
module rf_scoreboard_regfile import rf_pkg::*; #(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            lw_valid,
    input  logic [AW-1:0]   lw_addr,
    input  logic [XLEN-1:0] lw_data,
    output logic            lw_ready,
    output logic            busy_any,
    output logic            err_waw,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    logic [XLEN-1:0]        regs [NREGS];
    logic [NREGS-1:0]       pending;
    logic                   lw_fire;
    logic [2:0][AW-1:0]     rd_addr;
    logic [2:0][XLEN-1:0]   rd_val;

    // Main pipeline always wins the single write slot; write-back waits.
    assign lw_ready = !wr_en;
    assign lw_fire  = lw_valid && lw_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            if (wr_addr != AW'(ZERO_REG)) regs[wr_addr] <= wr_data;
        end else if (lw_fire && lw_addr != AW'(ZERO_REG)) begin
            regs[lw_addr] <= lw_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  err_waw <= 1'b0;
        else if (wr_en && wr_addr != AW'(ZERO_REG) && pending[wr_addr]) err_waw <= 1'b1;
    end

    rf_sb_bits #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set      (sb_set),
        .set_addr (sb_addr),
        .clr      (lw_fire),
        .clr_addr (lw_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .busy_any (busy_any),
        .pending  (pending)
    );

    assign rd_addr = {dbg_addr, rs2_addr, rs1_addr};

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_val[p] = regs[rd_addr[p]];
`ifdef RF_WRITE_BYPASS_EN
            if (!reset && rd_addr[p] != AW'(ZERO_REG)) begin
                if (wr_en && wr_addr == rd_addr[p])        rd_val[p] = wr_data;
                else if (lw_fire && lw_addr == rd_addr[p]) rd_val[p] = lw_data;
            end
`endif
        end
    end

    assign rs1_data = rd_val[0];
    assign rs2_data = rd_val[1];
    assign dbg_data = rd_val[2];
endmodule

// File: doc/rf_scoreboard_regfile.md
Name: rf_scoreboard_regfile

Overview:
- Parametrised successor to the integer register file; serves RV32I/RV32M cores with a multi-cycle mul/div unit.
- Two combinational read ports and a main-pipeline write port, plus a second handshaked write-back port for long-latency results.
- Per-register pending scoreboard so the decode stage can stall on RAW/WAW hazards against in-flight mul/div ops.
- One generic debug read tap.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  register value at rs1_addr (combinational)
rs2_data  out  XLEN  register value at rs2_addr (combinational)
rs1_busy  out  1  pending bit of rs1_addr
rs2_busy  out  1  pending bit of rs2_addr
wr_en  in  1  main pipeline write enable
wr_addr  in  AW  main write address
wr_data  in  XLEN  main write data
sb_set  in  1  long-latency op issued; mark sb_addr pending
sb_addr  in  AW  destination of issued long-latency op
lw_valid  in  1  long-latency write-back request
lw_addr  in  AW  long-latency write-back address
lw_data  in  XLEN  long-latency write-back data
lw_ready  out  1  write-back accepted this cycle
busy_any  out  1  OR of all pending bits
err_waw  out  1  sticky: main write hit a pending register
dbg_addr  in  AW  debug tap address
dbg_data  out  XLEN  register value at dbg_addr (combinational)

Behaviour:
- Reset (async, any time incl. mid-transfer): all registers 0, all pending 0, err_waw 0; outputs follow immediately (read data 0, busy 0, lw_ready = !wr_en).
- Register 0: reads always 0; writes from either port discarded; never pending (sb_set to 0 ignored). lw to addr 0 still handshakes (lw_ready as normal) and is dropped.
- Write latency: main or lw write visible on read ports the cycle after the accepting edge.
- Write-back handshake: lw_ready = !wr_en (main port has priority, no same-cycle dual write). Transfer when lw_valid && lw_ready. lw_addr/lw_data must hold stable while lw_valid && !lw_ready.
- Accepted lw write: writes lw_data, clears pending[lw_addr].
- Main write: writes wr_data; if pending[wr_addr]=1 (and addr!=0) sets err_waw; pending unchanged.
- Scoreboard same-cycle: sb_set and accepted lw clear to same address -> set wins (new issue). sb_set on already-pending reg -> stays 1.
- busy_any, rsN_busy reflect registered pending bits (no same-cycle bypass of set/clear).
- err_waw clears only on reset.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- Defined: rs1_data/rs2_data/dbg_data forward same-cycle write data when the address matches an active write (main wr_en, or accepted lw transfer); rsN_busy also reads 0 for an address being cleared by an accepted lw this cycle (unless sb_set same address). Addr 0 never forwarded.
- Undefined: reads see only registered state; one-cycle write-to-read latency.

Decomposition:
- Package rf_pkg: XLEN default, NREGS default, derived AW function, ZERO_REG constant, reg_addr_t / reg_data_t typedefs.
- Sub-module rf_sb_bits: NREGS pending flops with set/clear priority, busy lookups, busy_any. Top holds storage array, write arbitration, read muxes, bypass.

Test Plan:
- Reset then read all addrs -> data 0, busy 0, busy_any 0, err_waw 0, lw_ready 1.
- wr_en, wr_addr=5, wr_data=0xDEADBEEF; next cycle rs1_addr=5 -> 0xDEADBEEF; write addr 0 with 0x1234 -> rs2 of 0 reads 0.
- sb_set addr 10 -> next cycle rs1_busy=1 (rs1_addr=10), busy_any=1; lw_valid addr10 data 0x00000042 -> lw_ready=1, next cycle data 0x42, busy 0.
- lw_valid addr 7 together with wr_en addr 3 -> lw_ready=0, only x3 written; next cycle (wr_en=0) lw accepted, x7 updated.
- Same cycle sb_set addr 9 and accepted lw addr 9 -> x9 written, pending[9] stays 1; then wr_en addr 9 -> err_waw=1, sticky until reset.
- Assert reset mid-stall (lw_valid held) -> immediate zeroing; with RF_WRITE_BYPASS_EN, wr addr 4 data 0x55 reads 0x55 on rs1 same cycle, without it reads old value.
